pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter WORD, default 64, shall set the datapath and PC width in bits.
REQ-002 Parameter RESET_PC, default 64'h0, shall set the PC value loaded at reset.
REQ-003 clk  input  1  shall be the clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  shall be the reset: asynchronous, active-low.
REQ-005 redirect_i  input  1  shall be a branch/exception redirect request, sampled each cycle.
REQ-006 redirect_pc_i  input  WORD  shall be the redirect target PC.
REQ-007 imem_req_o  output  1  shall be the instruction-memory read request.
REQ-008 imem_addr_o  output  WORD  shall be the instruction-memory read address.
REQ-009 imem_ack_i  input  1  shall signal that imem_rdata_i is valid for the current request.
REQ-010 imem_rdata_i  input  32  shall be the instruction word returned by memory.
REQ-011 inst_valid_o  output  1  shall mark inst_o/inst_pc_o valid to the decode stage.
REQ-012 inst_ready_i  input  1  shall be decode-stage acceptance; transfer occurs when inst_valid_o && inst_ready_i.
REQ-013 inst_o  output  32  shall be the fetched instruction.
REQ-014 inst_pc_o  output  WORD  shall be the PC of inst_o.

Function
REQ-015 The block shall hold a registered fetch PC (pc_q) and a four-state FSM: IDLE, REQ, DROP, HOLD; all outputs registered or decoded from state/registers only.
REQ-016 IDLE: outputs idle; next state REQ unconditionally.
REQ-017 REQ: imem_req_o=1, imem_addr_o=pc_q; imem_addr_o and imem_req_o shall stay stable until imem_ack_i.
REQ-018 REQ with ack and no redirect: capture inst_o=imem_rdata_i, inst_pc_o=pc_q, pc_q<=pc_q+4, go HOLD.
REQ-019 HOLD: inst_valid_o=1, imem_req_o=0; inst_o/inst_pc_o stable until transfer; on transfer go REQ.
REQ-020 PC increment shall wrap modulo 2^WORD (all-ones-minus-3 + 4 -> 0).
REQ-021 Redirect targets shall be word-aligned by forcing bits [1:0] to 0.
REQ-022 Redirect in IDLE: pc_q<=target; go REQ.
REQ-023 Redirect in REQ with ack same cycle: discard rdata, pc_q<=target, stay REQ (new address next cycle).
REQ-024 Redirect in REQ without ack: pc_q<=target, go DROP; request and old address shall remain asserted (old address held in a separate register).
REQ-025 DROP: imem_req_o=1 with old address; on ack discard data and go REQ; further redirects in DROP update pc_q, last one wins.
REQ-026 Redirect in HOLD: drop held instruction (inst_valid_o=0 next cycle, even if transfer occurred same cycle -- transfer still counts as accepted), pc_q<=target, go REQ.
REQ-027 inst_valid_o shall never assert for a squashed instruction.
REQ-028 Latency: ack in cycle N -> inst_valid_o=1 in cycle N+1; transfer in cycle M -> imem_req_o=1 in M+1.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, pc_q=RESET_PC, imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
REQ-030 Reset mid-transaction shall abandon any outstanding request; an ack arriving in the first cycle after reset release shall be ignored.
REQ-031 First request after reset release shall be at RESET_PC on the second rising edge.

Structure
REQ-032 WORD default, instruction width 32, PC increment 4 and FSM state encodings shall live in the shared header common.vh.
REQ-033 One sub-module, pc_fetch_next (combinational next-PC select: pc+4 / aligned redirect target), is natural; the FSM and registers stay in pc_fetch.

Verification
REQ-034 Reset, RESET_PC=0x1000, ack every request, ready=1 -> addresses 0x1000,0x1004,0x1008; inst_pc_o matches each, one instruction per 2 cycles.
REQ-035 ready=0 for 5 cycles in HOLD -> inst_o/inst_pc_o stable, imem_req_o=0; ready=1 -> one transfer, next request at pc+4.
REQ-036 Redirect to 0x2002 while REQ waiting, ack 3 cycles later with 0xDEADBEEF -> address held during DROP, data never on inst_o, next request at 0x2000.
REQ-037 Redirect to 0x3000 in HOLD with ready=0 -> held instruction dropped, inst_valid_o=0, next request at 0x3000.
REQ-038 pc_q=0xFFFF_FFFF_FFFF_FFFC, ack -> next address 0x0.
REQ-039 rst_n low while DROP, ack arrives after release -> no inst_valid_o, request restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package pc_fetch_pkg;

  localparam int unsigned WORD_DEF = 64;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_next.sv
// Next fetch PC select: sequential pc+4 or word-aligned redirect target.
module pc_fetch_next
  import pc_fetch_pkg::*;
#(
  parameter int unsigned WORD = WORD_DEF
) (
  input  logic [WORD-1:0] pc,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic [WORD-1:0] next_pc_c
);

  // Redirect targets have their low two bits cleared; increment wraps naturally.
  assign next_pc_c = redirect ? (redirect_pc & ~WORD'(2'b11))
                              : (pc + WORD'(PC_INC));

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: issues imem reads, squashes on redirect,
// holds the fetched instruction until decode accepts it.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned      WORD     = WORD_DEF,
  parameter logic [WORD-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [WORD-1:0]   redirect_pc_i,
  output logic              imem_req_o,
  output logic [WORD-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [WORD-1:0]   inst_pc_o
);

  fetch_state_e      state_q, state_d;
  logic [WORD-1:0]   pc_q, pc_d;
  logic [WORD-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [WORD-1:0]   inst_pc_q, inst_pc_d;
  logic [WORD-1:0]   next_pc_c;

  pc_fetch_next #(.WORD(WORD)) u_next (
    .pc          (pc_q),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .next_pc_c   (next_pc_c)
  );

  // State and output registers; the outstanding address lives in addr_q,
  // separate from pc_q, so a redirect cannot disturb an in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state, PC update and registered-output precompute.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    req_d     = 1'b0;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect_i) pc_d = next_pc_c;
      end
      ST_REQ: begin
        if (imem_ack_i && redirect_i) begin
          pc_d = next_pc_c;
        end else if (imem_ack_i) begin
          inst_d    = imem_rdata_i;
          inst_pc_d = pc_q;
          pc_d      = next_pc_c;
          state_d   = ST_HOLD;
        end else if (redirect_i) begin
          pc_d    = next_pc_c;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (redirect_i) pc_d = next_pc_c;
        if (imem_ack_i) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_d    = next_pc_c;
          state_d = ST_REQ;
        end else if (inst_ready_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_REQ) addr_d = pc_d;
    req_d   = (state_d == ST_REQ) || (state_d == ST_DROP);
    valid_d = (state_d == ST_HOLD);
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected instructions are queued when the
// memory acks and compared when decode accepts them.
module tb_pc_fetch;

  localparam int unsigned WORD   = 64;
  localparam logic [63:0] RST_PC = 64'h1000;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_fetch #(.WORD(WORD), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode accepts the held instruction at the coming edge.
  task automatic accept();
    exp_t e;
    chk("valid_at_accept", 64'(inst_valid_o), 64'd1);
    inst_ready_i = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_has_entry", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("inst", 64'(inst_o), 64'(e.inst));
      chk("inst_pc", inst_pc_o, e.pc);
    end
  endtask

  // One full request/ack/hold/transfer round trip from a REQ state.
  task automatic fetch_one(input logic [63:0] exp_addr);
    exp_t e;
    chk("req", 64'(imem_req_o), 64'd1);
    chk("addr", imem_addr_o, exp_addr);
    imem_ack_i   = 1'b1;
    imem_rdata_i = mem_data(exp_addr);
    e.inst = mem_data(exp_addr);
    e.pc   = exp_addr;
    sb.push_back(e);
    step();
    imem_ack_i = 1'b0;
    chk("req_in_hold", 64'(imem_req_o), 64'd0);
    accept();
    step();
    inst_ready_i = 1'b0;
    chk("valid_after_xfer", 64'(inst_valid_o), 64'd0);
    chk("req_after_xfer", 64'(imem_req_o), 64'd1);
    chk("addr_next", imem_addr_o, exp_addr + 64'd4);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(imem_req_o), 64'd0);
    chk({tag, "_addr"}, imem_addr_o, 64'd0);
    chk({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
    chk({tag, "_inst"}, 64'(inst_o), 64'd0);
    chk({tag, "_inst_pc"}, inst_pc_o, 64'd0);
  endtask

  initial begin
    exp_t e;
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = '0;
    inst_ready_i  = 1'b0;

    // Reset values, then release with a stray ack that must be ignored.
    #3;
    chk_reset_outputs("rst");
    step();
    chk_reset_outputs("rst_hold");
    rst_n        = 1'b1;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hBAD0_BAD0;
    step();
    imem_ack_i = 1'b0;
    chk("first_req", 64'(imem_req_o), 64'd1);
    chk("first_addr", imem_addr_o, RST_PC);
    chk("stray_ack_valid", 64'(inst_valid_o), 64'd0);
    step();
    chk("req_wait_addr", imem_addr_o, RST_PC);
    chk("req_wait_valid", 64'(inst_valid_o), 64'd0);

    // Back-to-back sequential fetches.
    fetch_one(64'h1000);
    fetch_one(64'h1004);
    fetch_one(64'h1008);

    // Decode back-pressure for five cycles in HOLD.
    chk("bp_addr", imem_addr_o, 64'h100C);
    imem_ack_i   = 1'b1;
    imem_rdata_i = mem_data(64'h100C);
    e.inst = mem_data(64'h100C);
    e.pc   = 64'h100C;
    sb.push_back(e);
    step();
    imem_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(inst_valid_o), 64'd1);
      chk("bp_req", 64'(imem_req_o), 64'd0);
      chk("bp_inst", 64'(inst_o), 64'(sb[0].inst));
      chk("bp_inst_pc", inst_pc_o, sb[0].pc);
      step();
    end
    accept();
    step();
    inst_ready_i = 1'b0;
    chk("bp_next_req", 64'(imem_req_o), 64'd1);
    chk("bp_next_addr", imem_addr_o, 64'h1010);

    // Redirect while waiting for ack: old request held in DROP, data discarded.
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h2002;
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drop_req", 64'(imem_req_o), 64'd1);
      chk("drop_addr", imem_addr_o, 64'h1010);
      chk("drop_valid", 64'(inst_valid_o), 64'd0);
      step();
    end
    chk("drop_addr_last", imem_addr_o, 64'h1010);
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_ack_i = 1'b0;
    chk("after_drop_valid", 64'(inst_valid_o), 64'd0);
    chk("after_drop_inst", 64'(inst_o), 64'(mem_data(64'h100C)));
    fetch_one(64'h2000);

    // Redirect in HOLD without transfer: held instruction squashed.
    imem_ack_i   = 1'b1;
    imem_rdata_i = mem_data(64'h2004);
    step();
    imem_ack_i = 1'b0;
    chk("hold_sq_valid", 64'(inst_valid_o), 64'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h3000;
    step();
    redirect_i = 1'b0;
    chk("sq_valid", 64'(inst_valid_o), 64'd0);
    chk("sq_req", 64'(imem_req_o), 64'd1);
    chk("sq_addr", imem_addr_o, 64'h3000);
    fetch_one(64'h3000);

    // Redirect in HOLD with a same-cycle transfer: transfer counts, valid drops.
    imem_ack_i   = 1'b1;
    imem_rdata_i = mem_data(64'h3004);
    e.inst = mem_data(64'h3004);
    e.pc   = 64'h3004;
    sb.push_back(e);
    step();
    imem_ack_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h3103;
    accept();
    step();
    redirect_i   = 1'b0;
    inst_ready_i = 1'b0;
    chk("xfer_redir_valid", 64'(inst_valid_o), 64'd0);
    chk("xfer_redir_addr", imem_addr_o, 64'h3100);

    // Redirect with ack in REQ: data discarded, new address next cycle; then wrap.
    imem_ack_i    = 1'b1;
    imem_rdata_i  = 32'hCAFE_F00D;
    redirect_i    = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    imem_ack_i = 1'b0;
    redirect_i = 1'b0;
    chk("ackredir_valid", 64'(inst_valid_o), 64'd0);
    chk("ackredir_req", 64'(imem_req_o), 64'd1);
    chk("ackredir_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC);

    // Reset during DROP, ack right after release must be ignored.
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h5000;
    step();
    redirect_i = 1'b0;
    chk("pre_rst_drop_addr", imem_addr_o, 64'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 64'(imem_req_o), 64'd0);
    chk("async_rst_valid", 64'(inst_valid_o), 64'd0);
    chk("async_rst_addr", imem_addr_o, 64'd0);
    step();
    rst_n        = 1'b1;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'h0BAD_F00D;
    step();
    imem_ack_i = 1'b0;
    chk("rst2_valid", 64'(inst_valid_o), 64'd0);
    chk("rst2_addr", imem_addr_o, RST_PC);
    step();
    chk("rst2_valid_b", 64'(inst_valid_o), 64'd0);
    fetch_one(RST_PC);

    // Redirect in IDLE right after reset release.
    rst_n = 1'b0;
    #1;
    step();
    rst_n         = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h7001;
    step();
    redirect_i = 1'b0;
    chk("idle_redir_addr", imem_addr_o, 64'h7000);
    fetch_one(64'h7000);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
